alu_accum_seq: RTL and testbench

//  Parametrised ALU/accumulator. Operand A (switches) is combined with accumulator
//  low half B = ACC[W-1:0]; the result is written to a 2W-bit accumulator on a START strobe.

---
 rtl/alu_accum_seq.sv | 147 ++++++++++++++
 tb/tb_alu_accum_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accum_seq.sv
// ALU/accumulator: single-cycle ops on A and ACC[W-1:0], plus a W-step
// shift-add multiply that holds ACC until the product is ready.
module alu_accum_seq #(
  parameter int W      = 4,
  parameter int MUL_EN = 1
) (
  input  logic           CLK,
  input  logic           RESETb,
  input  logic [W-1:0]   A,
  input  logic [2:0]     OP,
  input  logic           START,
  output logic [2*W-1:0] ACC,
  output logic           C,
  output logic           ZERO,
  output logic           BUSY,
  output logic           DONE
);

  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD   = 3'b111;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_LOGIC = 3'b101;
  localparam logic [2:0] OP_ORRED = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_CAT   = 3'b010;
  localparam logic [2:0] OP_CLEAR = 3'b000;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t         state_q, state_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic           c_q, c_d;
  logic           done_q, done_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W-1:0]   b;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic           start_mul;
  logic           last_step;
  logic [2*W-1:0] step_prod;

  assign b         = acc_q[W-1:0];
  assign sum       = {1'b0, A} + {1'b0, b};
  // The W+1-bit difference carries the borrow as its sign bit.
  assign diff      = {1'b0, A} - {1'b0, b};
  assign start_mul = START && (state_q == S_IDLE) && (OP == OP_MUL) && (MUL_EN != 0);
  assign last_step = (cnt_q == CW'(W - 1));
  assign step_prod = prod_q + (mplier_q[0] ? mcand_q : '0);

  // State register
  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_mul) state_d = S_MUL;
      S_MUL:   if (last_step) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    BUSY = (state_q == S_MUL);
    ACC  = acc_q;
    C    = c_q;
    DONE = done_q;
    ZERO = (acc_q == '0);
  end

  always_comb begin
    acc_d    = acc_q;
    c_d      = c_q;
    done_d   = 1'b0;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (state_q == S_IDLE && START) begin
      if (start_mul) begin
        prod_d   = '0;
        mcand_d  = {{W{1'b0}}, A};
        mplier_d = b;
        cnt_d    = '0;
      end else begin
        done_d = 1'b1;
        case (OP)
          OP_ADD: begin
            acc_d = {{(W-1){1'b0}}, sum};
            c_d   = sum[W];
          end
          OP_SUB: begin
            acc_d = {{(W-1){diff[W]}}, diff};
            c_d   = diff[W];
          end
          OP_LOGIC: acc_d = {~(A & b), ~(A ^ b)};
          OP_ORRED: acc_d = (|{A, b}) ? {{W{1'b1}}, {W{1'b0}}} : '0;
          OP_CAT:   acc_d = {A, ~b};
          OP_CLEAR: acc_d = '0;
          default:  acc_d = acc_q;
        endcase
      end
    end else if (state_q == S_MUL) begin
      prod_d   = step_prod;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_step) begin
        acc_d  = step_prod;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      acc_q    <= '0;
      c_q      <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      c_q      <= c_d;
      done_q   <= done_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_accum_seq.sv
// Directed bench for alu_accum_seq (W=4): one instance with multiply enabled,
// one with it disabled.
module tb_alu_accum_seq;

  logic       CLK = 1'b0;
  logic       RESETb = 1'b0;
  logic [3:0] A = '0, a2 = '0;
  logic [2:0] OP = '0, op2 = '0;
  logic       START = 1'b0, start2 = 1'b0;
  logic [7:0] ACC, acc2;
  logic       C, ZERO, BUSY, DONE;
  logic       c2, zero2, busy2, done2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  alu_accum_seq #(.W(4), .MUL_EN(1)) dut (
    .CLK(CLK), .RESETb(RESETb), .A(A), .OP(OP), .START(START),
    .ACC(ACC), .C(C), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE)
  );

  alu_accum_seq #(.W(4), .MUL_EN(0)) dut_nomul (
    .CLK(CLK), .RESETb(RESETb), .A(a2), .OP(op2), .START(start2),
    .ACC(acc2), .C(c2), .ZERO(zero2), .BUSY(busy2), .DONE(done2)
  );

  // Issue one START on the main instance; returns 1 ns after the accepting edge.
  task automatic do_op(input logic [2:0] op, input logic [3:0] a);
    @(negedge CLK);
    A = a; OP = op; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    $display("[TB] op=%b A=%h -> ACC=%h C=%b DONE=%b BUSY=%b", op, a, ACC, C, DONE, BUSY);
  endtask

  task automatic do_op2(input logic [2:0] op, input logic [3:0] a);
    @(negedge CLK);
    a2 = a; op2 = op; start2 = 1'b1;
    @(posedge CLK);
    #1;
    start2 = 1'b0;
    $display("[TB] nomul op=%b A=%h -> ACC=%h DONE=%b BUSY=%b", op, a, acc2, done2, busy2);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    #2 RESETb = 1'b0;
    #1;
    tests_run++;
    if (ACC !== 8'h00 || C !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || ZERO !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset: ACC=%h C=%b BUSY=%b DONE=%b ZERO=%b, want 00 0 0 0 1", ACC, C, BUSY, DONE, ZERO);
    end
    @(negedge CLK);
    RESETb = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_add();
    do_op(3'b111, 4'h5);
    tests_run++;
    if (ACC !== 8'h05 || C !== 1'b0 || DONE !== 1'b1) begin
      tests_failed++;
      $display("FAIL add1: ACC=%h C=%b DONE=%b, want 05 0 1", ACC, C, DONE);
    end
    @(posedge CLK); #1;
    tests_run++;
    if (DONE !== 1'b0) begin
      tests_failed++;
      $display("FAIL add1_done_pulse: DONE=%b, want 0", DONE);
    end
    do_op(3'b111, 4'hB);
    tests_run++;
    if (ACC !== 8'h10 || C !== 1'b1 || ZERO !== 1'b0) begin
      tests_failed++;
      $display("FAIL add2: ACC=%h C=%b ZERO=%b, want 10 1 0", ACC, C, ZERO);
    end
  endtask

  task automatic test_sub();
    do_op(3'b000, 4'h0);
    do_op(3'b111, 4'h3);
    do_op(3'b110, 4'h2);
    tests_run++;
    if (ACC !== 8'hFF || C !== 1'b1) begin
      tests_failed++;
      $display("FAIL sub1: ACC=%h C=%b, want FF 1", ACC, C);
    end
    do_op(3'b000, 4'h0);
    do_op(3'b111, 4'h1);
    do_op(3'b110, 4'h9);
    tests_run++;
    if (ACC !== 8'h08 || C !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub2: ACC=%h C=%b, want 08 0", ACC, C);
    end
  endtask

  task automatic test_mul();
    do_op(3'b000, 4'h0);
    do_op(3'b111, 4'h7);
    do_op(3'b011, 4'hF);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (BUSY !== 1'b1 || ACC !== 8'h07 || DONE !== 1'b0 || ZERO !== 1'b0) begin
        tests_failed++;
        $display("FAIL mul_busy[%0d]: BUSY=%b ACC=%h DONE=%b ZERO=%b, want 1 07 0 0", i, BUSY, ACC, DONE, ZERO);
      end
      if (i == 1) begin
        A = 4'h1; OP = 3'b111; START = 1'b1;
      end
      @(posedge CLK); #1;
      START = 1'b0;
    end
    tests_run++;
    if (BUSY !== 1'b0 || ACC !== 8'h69 || DONE !== 1'b1 || C !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_result: BUSY=%b ACC=%h DONE=%b C=%b, want 0 69 1 0", BUSY, ACC, DONE, C);
    end
    $display("[TB] mul 7*F -> ACC=%h", ACC);
  endtask

  // DONE is still high from the multiply here; a new START must be taken.
  task automatic test_back_to_back();
    do_op(3'b000, 4'h0);
    tests_run++;
    if (ACC !== 8'h00 || DONE !== 1'b1 || ZERO !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_clear: ACC=%h DONE=%b ZERO=%b, want 00 1 1", ACC, DONE, ZERO);
    end
    do_op(3'b111, 4'h6);
    tests_run++;
    if (ACC !== 8'h06 || DONE !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_add: ACC=%h DONE=%b, want 06 1", ACC, DONE);
    end
  endtask

  task automatic test_abort();
    do_op(3'b000, 4'h0);
    do_op(3'b111, 4'h7);
    do_op(3'b011, 4'hF);
    @(posedge CLK);
    #2 RESETb = 1'b0;
    #1;
    tests_run++;
    if (ACC !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort: ACC=%h BUSY=%b DONE=%b, want 00 0 0", ACC, BUSY, DONE);
    end
    @(negedge CLK);
    RESETb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      tests_run++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || ACC !== 8'h00) begin
        tests_failed++;
        $display("FAIL abort_after[%0d]: DONE=%b BUSY=%b ACC=%h, want 0 0 00", i, DONE, BUSY, ACC);
      end
    end
    $display("[TB] abort checked");
  endtask

  task automatic test_bitops();
    do_op(3'b000, 4'h0);
    do_op(3'b111, 4'hA);
    do_op(3'b101, 4'hC);
    tests_run++;
    if (ACC !== 8'h79) begin
      tests_failed++;
      $display("FAIL logic: ACC=%h, want 79", ACC);
    end
    do_op(3'b000, 4'h0);
    do_op(3'b111, 4'h3);
    do_op(3'b010, 4'hA);
    tests_run++;
    if (ACC !== 8'hAC || C !== 1'b0) begin
      tests_failed++;
      $display("FAIL cat: ACC=%h C=%b, want AC 0", ACC, C);
    end
    do_op(3'b000, 4'h0);
    do_op(3'b100, 4'h0);
    tests_run++;
    if (ACC !== 8'h00 || ZERO !== 1'b1 || DONE !== 1'b1) begin
      tests_failed++;
      $display("FAIL orred_zero: ACC=%h ZERO=%b DONE=%b, want 00 1 1", ACC, ZERO, DONE);
    end
    do_op(3'b100, 4'h1);
    tests_run++;
    if (ACC !== 8'hF0) begin
      tests_failed++;
      $display("FAIL orred_one: ACC=%h, want F0", ACC);
    end
    // C set by an ADD carry must survive HOLD and CLEAR
    do_op(3'b111, 4'hF);
    do_op(3'b111, 4'h1);
    do_op(3'b001, 4'h3);
    tests_run++;
    if (ACC !== 8'h10 || C !== 1'b1 || DONE !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold: ACC=%h C=%b DONE=%b, want 10 1 1", ACC, C, DONE);
    end
    do_op(3'b000, 4'h3);
    tests_run++;
    if (ACC !== 8'h00 || C !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_keeps_c: ACC=%h C=%b, want 00 1", ACC, C);
    end
  endtask

  task automatic test_mul_disabled();
    do_op2(3'b111, 4'h5);
    do_op2(3'b011, 4'hF);
    tests_run++;
    if (acc2 !== 8'h05 || done2 !== 1'b1 || busy2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL nomul: ACC=%h DONE=%b BUSY=%b, want 05 1 0", acc2, done2, busy2);
    end
    @(posedge CLK); #1;
    tests_run++;
    if (acc2 !== 8'h05 || done2 !== 1'b0 || busy2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL nomul_after: ACC=%h DONE=%b BUSY=%b, want 05 0 0", acc2, done2, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_back_to_back();
    test_abort();
    test_bitops();
    test_mul_disabled();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
